// File: rtl/operand_feeder_if.sv
// Signal bundle between the operand loader (master) and operand_feeder (slave).
// It carries the byte-wide write port, the skewed edge operands and the status flags.
interface operand_feeder_if #(
    parameter int DATA_W = 8
);
    logic              load_en;
    logic              load_sel_ab;
    logic [1:0]        load_index;
    logic [DATA_W-1:0] in_data;

    logic [DATA_W-1:0] a_in0;
    logic [DATA_W-1:0] a_in1;
    logic [DATA_W-1:0] b_in0;
    logic [DATA_W-1:0] b_in1;
    logic              feed_valid;
    logic              acc_clr;
    logic              busy;
    logic              done;
    logic              overrun;
    logic [7:0]        loaded;

    modport master (
        output load_en, load_sel_ab, load_index, in_data,
        input  a_in0, a_in1, b_in0, b_in1,
        input  feed_valid, acc_clr, busy, done, overrun, loaded
    );

    modport slave (
        input  load_en, load_sel_ab, load_index, in_data,
        output a_in0, a_in1, b_in0, b_in1,
        output feed_valid, acc_clr, busy, done, overrun, loaded
    );
endinterface

// File: rtl/operand_feeder.sv
// Collects the 2x2 int8 A and B operands, then clears the array and feeds them
// diagonally skewed into its edges over three cycles.
module operand_feeder #(
    parameter int DATA_W = 8,
    parameter int N      = 2
) (
    input  logic             clk,
    input  logic             rst,
    operand_feeder_if.slave  bus
);
    localparam int NUM_OPS = 2 * N * N;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FEED  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           step_q, step_d;
    logic [NUM_OPS-1:0]   loaded_q, loaded_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 acc_clr_q, acc_clr_d;
    logic                 feed_valid_q, feed_valid_d;
    logic [DATA_W-1:0]    a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;

    logic                 wr_en;
    logic [2:0]           wr_addr;
    logic [NUM_OPS*DATA_W-1:0] op_flat;

    // Writes are only honoured while idle; anything else counts as an overrun.
    assign wr_en   = (state_q == S_IDLE) && bus.load_en;
    assign wr_addr = {bus.load_sel_ab, bus.load_index};

    // Element k of op_flat: 0..3 = A{00,01,10,11}, 4..7 = B{00,01,10,11}.
    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
            logic [DATA_W-1:0] elem_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    elem_q <= '0;
                end else if (wr_en && (wr_addr == 3'(gi))) begin
                    elem_q <= bus.in_data;
                end
            end
            assign op_flat[gi*DATA_W +: DATA_W] = elem_q;
        end
    endgenerate

    function automatic logic [DATA_W-1:0] op(input int k);
        return op_flat[k*DATA_W +: DATA_W];
    endfunction

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        loaded_d     = loaded_q;
        done_d       = done_q;
        overrun_d    = bus.load_en && (state_q != S_IDLE);
        a0_d         = '0;
        a1_d         = '0;
        b0_d         = '0;
        b1_d         = '0;

        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    loaded_d = loaded_q | (NUM_OPS'(1) << wr_addr);
                    done_d   = 1'b0;
                end
                if (loaded_d == {NUM_OPS{1'b1}}) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                step_d  = 2'd0;
            end
            S_FEED: begin
                if (step_q == 2'd2) begin
                    state_d  = S_IDLE;
                    step_d   = 2'd0;
                    loaded_d = '0;
                    done_d   = 1'b1;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Row i sees A[i][k] at step k+i, column j sees B[k][j] at step k+j.
        if (state_d == S_FEED) begin
            case (step_d)
                2'd0: begin
                    a0_d = op(0);
                    b0_d = op(4);
                end
                2'd1: begin
                    a0_d = op(1);
                    a1_d = op(2);
                    b0_d = op(6);
                    b1_d = op(5);
                end
                2'd2: begin
                    a1_d = op(3);
                    b1_d = op(7);
                end
                default: ;
            endcase
        end

        busy_d       = (state_d != S_IDLE);
        acc_clr_d    = (state_d == S_CLEAR);
        feed_valid_d = (state_d == S_FEED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            step_q       <= 2'd0;
            loaded_q     <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            acc_clr_q    <= 1'b0;
            feed_valid_q <= 1'b0;
            a0_q         <= '0;
            a1_q         <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            loaded_q     <= loaded_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            acc_clr_q    <= acc_clr_d;
            feed_valid_q <= feed_valid_d;
            a0_q         <= a0_d;
            a1_q         <= a1_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
        end
    end

    assign bus.a_in0      = a0_q;
    assign bus.a_in1      = a1_q;
    assign bus.b_in0      = b0_q;
    assign bus.b_in1      = b1_q;
    assign bus.feed_valid = feed_valid_q;
    assign bus.acc_clr    = acc_clr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;
    assign bus.loaded     = loaded_q;
endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: expected feed tuples go into a scoreboard
// queue and a negedge monitor pops one each time feed_valid is seen.
module tb_operand_feeder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_feeder_if #(.DATA_W(8)) bus ();
    operand_feeder #(.DATA_W(8), .N(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] b0;
        logic [7:0] b1;
    } feed_t;

    feed_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented feed beat must match the oldest expected tuple.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.feed_valid === 1'b1) begin
            feed_t got;
            got = {bus.a_in0, bus.a_in1, bus.b_in0, bus.b_in1};
            $display("feed a0=%h a1=%h b0=%h b1=%h", got.a0, got.a1, got.b0, got.b1);
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL feed_unexpected: got %h, expected no feed beat", got);
            end else begin
                feed_t e;
                e = sb.pop_front();
                chk("feed_beat", got, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic sel, input logic [1:0] idx, input logic [7:0] d);
        $display("write sel=%0d idx=%0d data=%h", sel, idx, d);
        bus.load_en     = 1'b1;
        bus.load_sel_ab = sel;
        bus.load_index  = idx;
        bus.in_data     = d;
        @(negedge clk);
        bus.load_en     = 1'b0;
    endtask

    task automatic push(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] b0, input logic [7:0] b1);
        sb.push_back(feed_t'{a0: a0, a1: a1, b0: b0, b1: b1});
    endtask

    // am/bm hold elements 0..3 from the most significant byte down.
    task automatic load_ab(input logic [31:0] am, input logic [31:0] bm);
        for (int i = 0; i < 4; i++) wr(1'b0, 2'(i), am[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) wr(1'b1, 2'(i), bm[31-8*i -: 8]);
    endtask

    // Called on the negedge right after the completing write (CLEAR cycle).
    task automatic feed_tail();
        chk("acc_clr_pulse", bus.acc_clr, 1'b1);
        chk("busy_in_clear", bus.busy, 1'b1);
        chk("no_feed_in_clear", bus.feed_valid, 1'b0);
        chk("done_low_in_clear", bus.done, 1'b0);
        tick(1);
        chk("acc_clr_one_cycle", bus.acc_clr, 1'b0);
        tick(3);
        chk("done_after_feed", bus.done, 1'b1);
        chk("loaded_cleared", bus.loaded, 8'h00);
        chk("busy_after_feed", bus.busy, 1'b0);
        chk("feed_off_after", bus.feed_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        bus.load_en     = 1'b0;
        bus.load_sel_ab = 1'b0;
        bus.load_index  = 2'd0;
        bus.in_data     = 8'h00;
        #2;
        chk("rst_outputs", {bus.a_in0, bus.a_in1, bus.b_in0, bus.b_in1}, 32'h0);
        chk("rst_flags", {bus.feed_valid, bus.acc_clr, bus.busy, bus.done, bus.overrun}, 5'b0);
        chk("rst_loaded", bus.loaded, 8'h00);
        tick(2);
        rst = 1'b0;

        // Basic load in index order.
        push(8'd1, 8'd0, 8'd5, 8'd0);
        push(8'd2, 8'd3, 8'd7, 8'd6);
        push(8'd0, 8'd4, 8'd0, 8'd8);
        load_ab(32'h01020304, 32'h05060708);
        feed_tail();
        tick(5);
        chk("done_holds", bus.done, 1'b1);

        // Write during FEED step k=1 is dropped and flagged.
        push(8'hFF, 8'h00, 8'h11, 8'h00);
        push(8'h02, 8'h03, 8'h33, 8'h22);
        push(8'h00, 8'hFC, 8'h00, 8'h44);
        load_ab(32'hFF0203FC, 32'h11223344);
        chk("acc_clr_ov", bus.acc_clr, 1'b1);
        tick(2);
        wr(1'b0, 2'd0, 8'd99);
        chk("overrun_pulse", bus.overrun, 1'b1);
        tick(1);
        chk("overrun_one_cycle", bus.overrun, 1'b0);
        chk("done_ov", bus.done, 1'b1);
        chk("loaded_ov", bus.loaded, 8'h00);

        // Seven elements, A00 rewritten twice, then the eighth.
        for (int i = 0; i < 4; i++) wr(1'b0, 2'(i), 8'(i + 1));
        for (int i = 0; i < 3; i++) wr(1'b1, 2'(i), 8'(i + 5));
        wr(1'b0, 2'd0, 8'd9);
        wr(1'b0, 2'd0, 8'h80);
        chk("loaded_seven", bus.loaded, 8'h7F);
        chk("busy_before_eighth", bus.busy, 1'b0);
        chk("done_cleared_by_write", bus.done, 1'b0);
        push(8'h80, 8'd0, 8'd5, 8'd0);
        push(8'd2, 8'd3, 8'd7, 8'd6);
        push(8'd0, 8'd4, 8'd0, 8'd8);
        wr(1'b1, 2'd3, 8'd8);
        feed_tail();

        // Single write after done.
        wr(1'b1, 2'd3, 8'd1);
        chk("done_drop", bus.done, 1'b0);
        chk("loaded_b11", bus.loaded, 8'h80);
        chk("busy_single", bus.busy, 1'b0);

        // B in reverse index order, then A.
        wr(1'b1, 2'd3, 8'd8);
        wr(1'b1, 2'd2, 8'd7);
        wr(1'b1, 2'd1, 8'd6);
        wr(1'b1, 2'd0, 8'd5);
        for (int i = 0; i < 3; i++) wr(1'b0, 2'(i), 8'(i + 1));
        chk("loaded_b_then_a", bus.loaded, 8'hF7);
        push(8'd1, 8'd0, 8'd5, 8'd0);
        push(8'd2, 8'd3, 8'd7, 8'd6);
        push(8'd0, 8'd4, 8'd0, 8'd8);
        wr(1'b0, 2'd3, 8'd4);
        feed_tail();

        // Reset asserted mid-cycle during step k=1.
        push(8'd1, 8'd0, 8'd5, 8'd0);
        push(8'd2, 8'd3, 8'd7, 8'd6);
        push(8'd0, 8'd4, 8'd0, 8'd8);
        load_ab(32'h01020304, 32'h05060708);
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_operands", {bus.a_in0, bus.a_in1, bus.b_in0, bus.b_in1}, 32'h0);
        chk("async_rst_flags", {bus.feed_valid, bus.acc_clr, bus.busy, bus.done, bus.overrun}, 5'b0);
        chk("async_rst_loaded", bus.loaded, 8'h00);
        sb.delete();
        tick(1);
        rst = 1'b0;
        push(8'h0A, 8'h00, 8'hF0, 8'h00);
        push(8'h0B, 8'h0C, 8'hD0, 8'hE0);
        push(8'h00, 8'h0D, 8'h00, 8'hC0);
        load_ab(32'h0A0B0C0D, 32'hF0E0D0C0);
        feed_tail();

        tick(2);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/operand_feeder.md
Name: operand_feeder

Overview:
- Upstream operand stage of the 2x2 matrix-multiply core. It accepts byte-wide operand writes from the pin-level load interface into a 2x2 A matrix and a 2x2 B matrix, all int8.
- Once all 8 operands are present, it clears the systolic array accumulators and streams the operands in diagonally skewed order into the array's row and column edge inputs.
- It then flags completion to the controller, which gates result readout.

Parameters:
- DATA_W, 8, operand width in bits (signed).
- N, 2, array dimension; the block is defined and verified for N=2 only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_en  input  1  operand write strobe; one write per cycle while high.
- load_sel_ab  input  1  0 = write matrix A, 1 = write matrix B.
- load_index  input  2  element index: {row,col}; 0=(0,0) 1=(0,1) 2=(1,0) 3=(1,1).
- in_data  input  8  operand byte, two's complement.
- a_in0  output  8  row-0 left-edge operand to the array (registered).
- a_in1  output  8  row-1 left-edge operand (registered).
- b_in0  output  8  column-0 top-edge operand (registered).
- b_in1  output  8  column-1 top-edge operand (registered).
- feed_valid  output  1  edge operands valid this cycle; the array shifts/MACs when high.
- acc_clr  output  1  one-cycle accumulator clear pulse to the array.
- busy  output  1  high in CLEAR and FEED.
- done  output  1  high from end of feed until the next accepted write.
- overrun  output  1  one-cycle pulse when a write is dropped.
- loaded  output  8  valid bitmap; [3:0] = A elements 0..3, [7:4] = B elements 0..3.

Behaviour:
- Reset (async, any state): state=IDLE; all operand registers and loaded=0; a_in*/b_in*=0; feed_valid, acc_clr, busy, done, overrun=0.
- IDLE:
  - load_en=1 writes in_data to element {load_sel_ab,load_index} and sets its loaded bit at the clock edge.
  - Rewriting an already-set element overwrites the value; the bitmap is unchanged.
  - Any accepted write clears done.
- IDLE -> CLEAR: on the edge where loaded becomes 8'hFF, including when the completing write lands that edge.
- CLEAR (1 cycle): acc_clr=1, busy=1, feed_valid=0, edge operands 0.
- FEED (3 cycles, step k=0..2): feed_valid=1, busy=1. Values, registered and presented during step k:
  - k=0: a_in0=A00, a_in1=0, b_in0=B00, b_in1=0.
  - k=1: a_in0=A01, a_in1=A10, b_in0=B10, b_in1=B01.
  - k=2: a_in0=0, a_in1=A11, b_in0=0, b_in1=B11.
  - Rule: row i gets A[i][k'] at step k'+i; column j gets B[k'][j] at step k'+j; unused slots are 0.
- After k=2 -> IDLE:
  - done=1, loaded cleared to 0, operand registers retained.
  - Edge operands return to 0 with feed_valid=0, so the array drains with zeros.
- Latency: 8th write edge -> acc_clr high next cycle -> feed_valid high cycles 2..4 -> done high cycle 5.
- Writes while busy=1 are dropped (no register or bitmap change); overrun pulses the following cycle.
- A write in the same cycle the block returns to IDLE (the edge ending k=2) is also dropped.
- done stays high with no load_en indefinitely.
- No arithmetic in this block; operands are passed bit-exact (no sign extension).

Test Plan:
- Reset mid-FEED (assert rst during k=1) -> all outputs 0 immediately (async), loaded=0, state IDLE; a following full load runs a normal feed.
- Load A=[[1,2],[3,4]], B=[[5,6],[7,8]] in index order -> acc_clr one cycle, then (a0,a1,b0,b1) = (1,0,5,0), (2,3,7,6), (0,4,0,8), then done=1, loaded=0.
- Load 7 elements, rewrite A00 twice (9 then -128 = 8'h80), then the 8th element -> no feed before the 8th; step k=0 shows a_in0=8'h80.
- Write during FEED step k=1 (A00=99) -> overrun pulses one cycle, feed values unchanged, loaded stays 0 after done.
- After done, a single write B11=1 -> done drops next cycle, loaded=8'h80, busy=0.
- Load B first in reverse index order, then A -> identical feed sequence to the second scenario for the same matrices.
